// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory subsystem: geometry, arbiter states, requester ids.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 10;
  localparam int unsigned DMEM_DATA_W = 18;

  localparam int unsigned REQ_CPU    = 0;
  localparam int unsigned REQ_LOADER = 1;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin selector: first unmasked request at or after start, with wrap.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  input  logic [N-1:0]     skip,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned      j;
      logic [IDX_W-1:0] jj;
      j = 32'(start) + k;
      if (j >= N) j = j - N;
      jj = IDX_W'(j);
      if (!valid && req[jj] && !skip[jj]) begin
        valid      = 1'b1;
        onehot[jj] = 1'b1;
        idx        = jj;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared single-port data memory, with bounded locked bursts.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned ADDR_W    = DMEM_ADDR_W,
  parameter int unsigned DATA_W    = DMEM_DATA_W,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     mem_write_en,
  output logic                     mem_read_en,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_in_data,
  input  logic [DATA_W-1:0]        mem_out_data,
  output logic                     busy
);

  localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_BURST);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (32'(i) >= N_REQ - 1) return '0;
    return i + 1'b1;
  endfunction

  arb_state_e         state_q;
  logic [IDX_W-1:0]   own_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [BCNT_W-1:0]  bcnt_q;
  logic [N_REQ-1:0]   rvalid_q;

  logic [N_REQ-1:0]   owner_mask;
  logic               others_req;
  logic               force_rel;
  logic               keep;
  logic [IDX_W-1:0]   pick_start;
  logic [N_REQ-1:0]   pick_skip;
  logic [N_REQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [N_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;

  always_comb begin
    owner_mask = N_REQ'(1) << own_q;
    others_req = |(req & ~owner_mask);
    force_rel  = (state_q == ARB_OWNED) && (bcnt_q == BCNT_MAX) && others_req;
    keep       = (state_q == ARB_OWNED) && req[own_q] && lock[own_q] && !force_rel;
    // A forced release restarts the search just past the owner and hides it.
    pick_start = force_rel ? next_idx(own_q) : ptr_q;
    pick_skip  = force_rel ? owner_mask : '0;
  end

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .start  (pick_start),
    .skip   (pick_skip),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    win_onehot = keep ? owner_mask : pick_onehot;
    win_idx    = keep ? own_q : pick_idx;
    win_valid  = !reset && (keep || pick_valid);

    gnt          = win_valid ? win_onehot : '0;
    mem_write_en = win_valid && we[win_idx];
    mem_read_en  = win_valid && !we[win_idx];
    mem_address  = win_valid ? addr[win_idx*ADDR_W +: ADDR_W] : '0;
    mem_in_data  = win_valid ? wdata[win_idx*DATA_W +: DATA_W] : '0;

    // Gating with reset drops a read return that lands in the reset cycle.
    rvalid = reset ? '0 : rvalid_q;
    rdata  = (!reset && |rvalid_q) ? mem_out_data : '0;
    busy   = |gnt || |rvalid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      own_q    <= '0;
      ptr_q    <= '0;
      bcnt_q   <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt & ~we;
      if (keep) begin
        if (bcnt_q != BCNT_MAX) bcnt_q <= bcnt_q + 1'b1;
      end else if (pick_valid) begin
        if (lock[pick_idx]) begin
          state_q <= ARB_OWNED;
          own_q   <= pick_idx;
          bcnt_q  <= BCNT_W'(1);
        end else begin
          state_q <= ARB_IDLE;
          ptr_q   <= next_idx(pick_idx);
          bcnt_q  <= '0;
        end
      end else begin
        state_q <= ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1024x18 synchronous data memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req, we, lock;
  logic [19:0] addr;
  logic [35:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [17:0] rdata;
  logic        mem_write_en, mem_read_en;
  logic [9:0]  mem_address;
  logic [17:0] mem_in_data, mem_out_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(
    .N_REQ     (2),
    .ADDR_W    (10),
    .DATA_W    (18),
    .MAX_BURST (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .we           (we),
    .lock         (lock),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_address  (mem_address),
    .mem_in_data  (mem_in_data),
    .mem_out_data (mem_out_data),
    .busy         (busy)
  );

  logic [17:0] mem [1024];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address] <= mem_in_data;
    if (mem_read_en) mem_out_data <= mem[mem_address];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req, we, lock;
    logic [9:0]  a0, a1;
    logic [17:0] d0, d1;
    logic [1:0]  gnt, rv;
    logic [17:0] rdata;
    logic        mwe, mre;
    logic [9:0]  maddr;
    logic [17:0] mdin;
    logic        busy;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                       input logic [9:0] a0, input logic [9:0] a1,
                       input logic [17:0] d0, input logic [17:0] d1);
    req   = r;
    we    = w;
    lock  = l;
    addr  = {a1, a0};
    wdata = {d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 18'd0, 18'd0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 18'd0, 18'd0);
    vecs[0]  = '{2'b00, 2'b00, 2'b00, 10'd0,   10'd0,   18'd0,     18'd0,
                 2'b00, 2'b00, 18'd0,        1'b0, 1'b0, 10'd0,   18'd0,        1'b0};
    vecs[1]  = '{2'b10, 2'b10, 2'b00, 10'd0,   10'h3FF, 18'd0,     18'h2A5A,
                 2'b10, 2'b00, 18'd0,        1'b1, 1'b0, 10'h3FF, 18'h2A5A,     1'b1};
    vecs[2]  = '{2'b01, 2'b00, 2'b00, 10'h3FF, 10'd0,   18'd0,     18'd0,
                 2'b01, 2'b00, 18'd0,        1'b0, 1'b1, 10'h3FF, 18'd0,        1'b1};
    vecs[3]  = '{2'b00, 2'b00, 2'b00, 10'd0,   10'd0,   18'd0,     18'd0,
                 2'b00, 2'b01, 18'h2A5A,     1'b0, 1'b0, 10'd0,   18'd0,        1'b1};
    vecs[4]  = '{2'b11, 2'b11, 2'b00, 10'd5,   10'd6,   18'h155,   18'h2AAAA,
                 2'b10, 2'b00, 18'd0,        1'b1, 1'b0, 10'd6,   18'h2AAAA,    1'b1};
    vecs[5]  = '{2'b01, 2'b01, 2'b00, 10'd5,   10'd0,   18'h155,   18'd0,
                 2'b01, 2'b00, 18'd0,        1'b1, 1'b0, 10'd5,   18'h155,      1'b1};
    vecs[6]  = '{2'b11, 2'b00, 2'b00, 10'd5,   10'd6,   18'd0,     18'd0,
                 2'b10, 2'b00, 18'd0,        1'b0, 1'b1, 10'd6,   18'd0,        1'b1};
    vecs[7]  = '{2'b01, 2'b00, 2'b00, 10'd5,   10'd0,   18'd0,     18'd0,
                 2'b01, 2'b10, 18'h2AAAA,    1'b0, 1'b1, 10'd5,   18'd0,        1'b1};
    vecs[8]  = '{2'b11, 2'b00, 2'b00, 10'd5,   10'd6,   18'd0,     18'd0,
                 2'b10, 2'b01, 18'h155,      1'b0, 1'b1, 10'd6,   18'd0,        1'b1};
    vecs[9]  = '{2'b01, 2'b00, 2'b00, 10'd5,   10'd0,   18'd0,     18'd0,
                 2'b01, 2'b10, 18'h2AAAA,    1'b0, 1'b1, 10'd5,   18'd0,        1'b1};
    vecs[10] = '{2'b00, 2'b00, 2'b00, 10'd0,   10'd0,   18'd0,     18'd0,
                 2'b00, 2'b01, 18'h155,      1'b0, 1'b0, 10'd0,   18'd0,        1'b1};

    // Requests held through reset must not be granted until reset drops.
    tick();
    drive(2'b11, 2'b00, 2'b00, 10'd1, 10'd2, 18'd0, 18'd0);
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("rst%0d gnt", c), 32'(gnt), 32'd0);
      check($sformatf("rst%0d rvalid", c), 32'(rvalid), 32'd0);
      check($sformatf("rst%0d rdata", c), 32'(rdata), 32'd0);
      check($sformatf("rst%0d busy", c), 32'(busy), 32'd0);
      check($sformatf("rst%0d strobes", c), 32'({mem_write_en, mem_read_en}), 32'd0);
      check($sformatf("rst%0d maddr", c), 32'(mem_address), 32'd0);
      tick();
    end
    reset = 1'b0;
    #1;
    check("post_rst gnt0", 32'(gnt), 32'b01);
    tick();
    check("post_rst gnt1", 32'(gnt), 32'b10);
    check("post_rst rvalid", 32'(rvalid), 32'b01);
    tick();

    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].lock, vecs[i].a0, vecs[i].a1,
            vecs[i].d0, vecs[i].d1);
      #1;
      check($sformatf("v%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
      check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].rdata));
      check($sformatf("v%0d mem_we", i), 32'(mem_write_en), 32'(vecs[i].mwe));
      check($sformatf("v%0d mem_re", i), 32'(mem_read_en), 32'(vecs[i].mre));
      check($sformatf("v%0d maddr", i), 32'(mem_address), 32'(vecs[i].maddr));
      check($sformatf("v%0d mdin", i), 32'(mem_in_data), 32'(vecs[i].mdin));
      check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      tick();
    end

    // Locked burst: owner keeps 8 grants, competitor gets one, owner resumes.
    do_reset();
    for (int c = 1; c <= 13; c++) begin
      logic r1;
      r1 = (c >= 2) && (c <= 9);
      drive({r1, 1'b1}, 2'b00, 2'b01, 10'd5, 10'd6, 18'd0, 18'd0);
      #1;
      check($sformatf("burst c%0d gnt", c), 32'(gnt), (c == 9) ? 32'b10 : 32'b01);
      tick();
    end

    // Voluntary release: final unlocked grant moves ptr to 1 and returns to idle.
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      logic [1:0] r;
      logic [1:0] l;
      r = (c <= 3) ? 2'b01 : 2'b11;
      l = (c <= 2) ? 2'b01 : 2'b00;
      drive(r, 2'b00, l, 10'd5, 10'd6, 18'd0, 18'd0);
      #1;
      check($sformatf("vrel c%0d gnt", c), 32'(gnt), (c == 4) ? 32'b10 : 32'b01);
      tick();
    end

    // Reset asserted the cycle after a read grant discards the pending rvalid.
    do_reset();
    drive(2'b01, 2'b00, 2'b00, 10'd5, 10'd0, 18'd0, 18'd0);
    #1;
    check("rstrd gnt", 32'(gnt), 32'b01);
    tick();
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 18'd0, 18'd0);
    #1;
    check("rstrd rvalid_in_rst", 32'(rvalid), 32'd0);
    check("rstrd rdata_in_rst", 32'(rdata), 32'd0);
    check("rstrd busy_in_rst", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("rstrd rvalid_after", 32'(rvalid), 32'd0);
    check("rstrd busy_after", 32'(busy), 32'd0);
    tick();

    // Both requesters read continuously: grants alternate and data follows its owner.
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      logic [1:0] exp_g;
      logic [1:0] exp_rv;
      exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_rv = (k == 0) ? 2'b00 : ((k % 2 == 1) ? 2'b01 : 2'b10);
      if (k < 10) drive(2'b11, 2'b00, 2'b00, 10'd5, 10'd6, 18'd0, 18'd0);
      else        drive(2'b00, 2'b00, 2'b00, 10'd0, 10'd0, 18'd0, 18'd0);
      #1;
      if (k < 10) check($sformatf("alt k%0d gnt", k), 32'(gnt), 32'(exp_g));
      check($sformatf("alt k%0d rvalid", k), 32'(rvalid), 32'(exp_rv));
      if (k > 0)
        check($sformatf("alt k%0d rdata", k), 32'(rdata),
              (k % 2 == 1) ? 32'h155 : 32'h2AAAA);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
